mod_n_counter_chain: RTL and testbench



---
 rtl/mod_n_counter_chain_if.sv | 27 ++
 rtl/mod_n_counter_chain.sv | 92 +++++++++
 tb/tb_mod_n_counter_chain.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_counter_chain_if.sv
// Control and count bundle for the cascaded mod-N counter chain.
// The master drives the controls; the counter (slave) returns count and status.
interface mod_n_counter_chain_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
);
    logic                    en;
    logic                    up_dn;
    logic                    hold_tc;
    logic                    load;
    logic [DIGITS*WIDTH-1:0] load_val;
    logic [DIGITS*WIDTH-1:0] q;
    logic                    tc;
    logic                    wrap;
    logic                    done;
    logic                    load_err;

    modport master (
        output en, up_dn, hold_tc, load, load_val,
        input  q, tc, wrap, done, load_err
    );

    modport slave (
        input  en, up_dn, hold_tc, load, load_val,
        output q, tc, wrap, done, load_err
    );
endinterface

// File: rtl/mod_n_counter_chain.sv
// Fully synchronous chain of DIGITS cascaded mod-MODULUS digits with
// up/down count, sanitising parallel load, one-shot hold and cascade outputs.
module mod_n_counter_chain #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4,
    parameter int DIGITS  = 2
) (
    input logic                  clk,
    input logic                  clear,
    mod_n_counter_chain_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);

    logic [DIGITS-1:0][WIDTH-1:0] count_q, count_d;
    logic                         wrap_q, wrap_d;
    logic                         done_q, done_d;
    logic                         load_err_q, load_err_d;
    logic [DIGITS-1:0]            at_max, at_zero;
    logic                         term;
    logic                         carry;

    always_comb begin
        at_max  = '0;
        at_zero = '0;
        for (int i = 0; i < DIGITS; i++) begin
            at_max[i]  = (count_q[i] == MAX);
            at_zero[i] = (count_q[i] == '0);
        end
    end

    assign term = bus.up_dn ? (&at_max) : (&at_zero);

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        done_d     = done_q;
        load_err_d = 1'b0;
        carry      = 1'b1;
        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (bus.load) begin
            done_d = 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                if ({1'b0, bus.load_val[i*WIDTH +: WIDTH]} >= MOD_W) begin
                    count_d[i] = '0;
                    load_err_d = 1'b1;
                end else begin
                    count_d[i] = bus.load_val[i*WIDTH +: WIDTH];
                end
            end
        end else if (bus.en) begin
            if (term && bus.hold_tc) begin
                done_d = 1'b1;
            end else begin
                // Stepping from terminal rolls every digit, which is the wrap.
                done_d = 1'b0;
                wrap_d = term;
                for (int i = 0; i < DIGITS; i++) begin
                    if (carry) begin
                        if (bus.up_dn)
                            count_d[i] = at_max[i] ? '0 : count_q[i] + WIDTH'(1);
                        else
                            count_d[i] = at_zero[i] ? MAX : count_q[i] - WIDTH'(1);
                    end
                    carry = carry & (bus.up_dn ? at_max[i] : at_zero[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.q        = count_q;
    assign bus.tc       = bus.en & term & ~bus.load & ~clear;
    assign bus.wrap     = wrap_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_mod_n_counter_chain.sv
// Directed bench: 2-digit BCD chain plus a 1-digit binary corner instance.
module tb_mod_n_counter_chain;
    logic clk;
    logic clear_a;
    logic clear_b;
    int   checks;
    int   failures;

    mod_n_counter_chain_if #(.WIDTH(4), .DIGITS(2)) ifa ();
    mod_n_counter_chain_if #(.WIDTH(4), .DIGITS(1)) ifb ();

    mod_n_counter_chain #(.MODULUS(10), .WIDTH(4), .DIGITS(2)) dut_a (
        .clk   (clk),
        .clear (clear_a),
        .bus   (ifa.slave)
    );

    mod_n_counter_chain #(.MODULUS(16), .WIDTH(4), .DIGITS(1)) dut_b (
        .clk   (clk),
        .clear (clear_b),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_a();
        clear_a      = 1'b0;
        ifa.en       = 1'b0;
        ifa.up_dn    = 1'b1;
        ifa.hold_tc  = 1'b0;
        ifa.load     = 1'b0;
        ifa.load_val = 8'h00;
    endtask

    task automatic load_a(input logic [7:0] v);
        ifa.load     = 1'b1;
        ifa.load_val = v;
        tick();
        ifa.load     = 1'b0;
    endtask

    task automatic test_reset();
        clear_a = 1'b1;
        ifa.en  = 1'b1;
        tick();
        checks++;
        if (ifa.q !== 8'h00 || ifa.wrap !== 1'b0 || ifa.done !== 1'b0 ||
            ifa.load_err !== 1'b0) begin
            $display("FAIL reset: q=%h wrap=%b done=%b err=%b want 00/0/0/0",
                     ifa.q, ifa.wrap, ifa.done, ifa.load_err);
            failures++;
        end
        checks++;
        if (ifa.tc !== 1'b0) begin
            $display("FAIL reset_tc: tc=%b want 0", ifa.tc);
            failures++;
        end
        idle_a();
    endtask

    task automatic test_up_wrap();
        int n;
        clear_a = 1'b1;
        tick();
        clear_a     = 1'b0;
        ifa.en      = 1'b1;
        ifa.up_dn   = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (ifa.tc !== (n == 99)) begin
                $display("FAIL up_tc: n=%0d tc=%b want %b", n, ifa.tc, n == 99);
                failures++;
            end
            tick();
            checks++;
            if (ifa.q !== bcd((n + 1) % 100) || ifa.wrap !== (n == 99)) begin
                $display("FAIL up_step: q=%h wrap=%b want %h/%b",
                         ifa.q, ifa.wrap, bcd((n + 1) % 100), n == 99);
                failures++;
            end
            n = (n + 1) % 100;
        end
        checks++;
        if (ifa.q !== 8'h00) begin
            $display("FAIL up_final: q=%h want 00", ifa.q);
            failures++;
        end
        idle_a();
    endtask

    task automatic test_down_borrow();
        load_a(8'h10);
        ifa.en    = 1'b1;
        ifa.up_dn = 1'b0;
        tick();
        checks++;
        if (ifa.q !== 8'h09 || ifa.wrap !== 1'b0) begin
            $display("FAIL down_borrow: q=%h wrap=%b want 09/0", ifa.q, ifa.wrap);
            failures++;
        end
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (ifa.q !== 8'h00 || ifa.tc !== 1'b1) begin
            $display("FAIL down_zero: q=%h tc=%b want 00/1", ifa.q, ifa.tc);
            failures++;
        end
        tick();
        checks++;
        if (ifa.q !== 8'h99 || ifa.wrap !== 1'b1 || ifa.tc !== 1'b0) begin
            $display("FAIL down_wrap: q=%h wrap=%b tc=%b want 99/1/0",
                     ifa.q, ifa.wrap, ifa.tc);
            failures++;
        end
        tick();
        checks++;
        if (ifa.q !== 8'h98 || ifa.wrap !== 1'b0) begin
            $display("FAIL down_after: q=%h wrap=%b want 98/0", ifa.q, ifa.wrap);
            failures++;
        end
        idle_a();
    endtask

    task automatic test_one_shot();
        ifa.hold_tc = 1'b1;
        load_a(8'h97);
        ifa.en    = 1'b1;
        ifa.up_dn = 1'b1;
        tick();
        tick();
        checks++;
        if (ifa.q !== 8'h99 || ifa.done !== 1'b0 || ifa.tc !== 1'b1) begin
            $display("FAIL shot_reach: q=%h done=%b tc=%b want 99/0/1",
                     ifa.q, ifa.done, ifa.tc);
            failures++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifa.q !== 8'h99 || ifa.done !== 1'b1 || ifa.wrap !== 1'b0) begin
                $display("FAIL shot_hold: q=%h done=%b wrap=%b want 99/1/0",
                         ifa.q, ifa.done, ifa.wrap);
                failures++;
            end
        end
        ifa.up_dn = 1'b0;
        #1;
        checks++;
        if (ifa.tc !== 1'b0) begin
            $display("FAIL shot_flip_tc: tc=%b want 0", ifa.tc);
            failures++;
        end
        tick();
        checks++;
        if (ifa.q !== 8'h98 || ifa.done !== 1'b0) begin
            $display("FAIL shot_flip: q=%h done=%b want 98/0", ifa.q, ifa.done);
            failures++;
        end
        idle_a();
    endtask

    task automatic test_illegal_load();
        load_a(8'hA5);
        checks++;
        if (ifa.q !== 8'h05 || ifa.load_err !== 1'b1) begin
            $display("FAIL ld_a5: q=%h err=%b want 05/1", ifa.q, ifa.load_err);
            failures++;
        end
        tick();
        checks++;
        if (ifa.q !== 8'h05 || ifa.load_err !== 1'b0) begin
            $display("FAIL ld_a5_pulse: q=%h err=%b want 05/0", ifa.q, ifa.load_err);
            failures++;
        end
        load_a(8'h3C);
        checks++;
        if (ifa.q !== 8'h30 || ifa.load_err !== 1'b1) begin
            $display("FAIL ld_3c: q=%h err=%b want 30/1", ifa.q, ifa.load_err);
            failures++;
        end
        load_a(8'h42);
        checks++;
        if (ifa.q !== 8'h42 || ifa.load_err !== 1'b0) begin
            $display("FAIL ld_42: q=%h err=%b want 42/0", ifa.q, ifa.load_err);
            failures++;
        end
        idle_a();
    endtask

    task automatic test_priority();
        ifa.en    = 1'b1;
        ifa.up_dn = 1'b1;
        load_a(8'h55);
        checks++;
        if (ifa.q !== 8'h55) begin
            $display("FAIL prio_load: q=%h want 55", ifa.q);
            failures++;
        end
        load_a(8'h99);
        ifa.load     = 1'b1;
        ifa.load_val = 8'h12;
        #1;
        checks++;
        if (ifa.tc !== 1'b0) begin
            $display("FAIL prio_tc_load: tc=%b want 0", ifa.tc);
            failures++;
        end
        clear_a = 1'b1;
        tick();
        checks++;
        if (ifa.q !== 8'h00) begin
            $display("FAIL prio_clear_load: q=%h want 00", ifa.q);
            failures++;
        end
        clear_a     = 1'b0;
        ifa.load    = 1'b0;
        ifa.hold_tc = 1'b1;
        load_a(8'h99);
        tick();
        checks++;
        if (ifa.done !== 1'b1) begin
            $display("FAIL prio_done_set: done=%b want 1", ifa.done);
            failures++;
        end
        clear_a = 1'b1;
        #1;
        checks++;
        if (ifa.tc !== 1'b0) begin
            $display("FAIL prio_tc_clear: tc=%b want 0", ifa.tc);
            failures++;
        end
        tick();
        checks++;
        if (ifa.q !== 8'h00 || ifa.done !== 1'b0) begin
            $display("FAIL prio_clear_done: q=%h done=%b want 00/0", ifa.q, ifa.done);
            failures++;
        end
        idle_a();
    endtask

    task automatic test_binary();
        clear_b = 1'b1;
        tick();
        clear_b   = 1'b0;
        ifb.en    = 1'b1;
        ifb.up_dn = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (ifb.q !== 4'hF || ifb.tc !== 1'b1) begin
            $display("FAIL bin_max: q=%h tc=%b want f/1", ifb.q, ifb.tc);
            failures++;
        end
        tick();
        checks++;
        if (ifb.q !== 4'h0 || ifb.wrap !== 1'b1) begin
            $display("FAIL bin_wrap: q=%h wrap=%b want 0/1", ifb.q, ifb.wrap);
            failures++;
        end
        tick();
        checks++;
        if (ifb.q !== 4'h1 || ifb.wrap !== 1'b0) begin
            $display("FAIL bin_after: q=%h wrap=%b want 1/0", ifb.q, ifb.wrap);
            failures++;
        end
        ifb.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifb.q !== 4'h1 || ifb.tc !== 1'b0 || ifb.wrap !== 1'b0) begin
                $display("FAIL bin_hold: q=%h tc=%b wrap=%b want 1/0/0",
                         ifb.q, ifb.tc, ifb.wrap);
                failures++;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_a();
        clear_b      = 1'b1;
        ifb.en       = 1'b0;
        ifb.up_dn    = 1'b1;
        ifb.hold_tc  = 1'b0;
        ifb.load     = 1'b0;
        ifb.load_val = 4'h0;
        tick();
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_one_shot();
        test_illegal_load();
        test_priority();
        test_binary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
